// File: rtl/fetch_pc_ctrl.sv
// F-stage fetch PC register and next-PC select for the 5-stage MIPS pipeline.
// Optional exception/eret redirect and FLUSH state are enabled by FETCH_PC_EXC_EN.
//
// state | meaning
// RUN   | normal fetch; branch/jump redirects from D are honoured
// FLUSH | D holds a flushed instr after exc/eret; its br/j/jr are ignored
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
`ifdef FETCH_PC_EXC_EN
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
`endif
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_en,
  input  logic        br_flag,
  input  logic        j_en,
  input  logic        jr_en,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
`ifdef FETCH_PC_EXC_EN
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
`endif
  output logic [31:0] pc_f,
  output logic        adel_f,
  output logic        redirect,
  output logic [31:0] br_taken_cnt
);

  logic [31:0] pc_seq;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_next;
  logic        redirect_next;
  logic        br_inc;

  assign pc_seq    = pc_f + 32'd4;
  assign br_target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_d[31:28], instr_index, 2'b00};
  assign adel_f    = (pc_f[1:0] != 2'b00) | (pc_f < IMEM_LO) | (pc_f > IMEM_HI);

`ifdef FETCH_PC_EXC_EN
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end
`endif

  always_comb begin
    pc_next       = pc_seq;
    redirect_next = 1'b0;
    br_inc        = 1'b0;
`ifdef FETCH_PC_EXC_EN
    state_d       = RUN;
    if (exc_req) begin
      pc_next       = EXC_PC;
      redirect_next = 1'b1;
      state_d       = FLUSH;
    end else if (eret) begin
      pc_next       = epc;
      redirect_next = 1'b1;
      state_d       = FLUSH;
    end else if (state_q == FLUSH) begin
      // flushed D instr: fall through sequentially even under stall
      pc_next = pc_seq;
    end else
`endif
    if (stall) begin
      pc_next = pc_f;
    end else if (jr_en) begin
      pc_next       = rs_val;
      redirect_next = 1'b1;
    end else if (j_en) begin
      pc_next       = j_target;
      redirect_next = 1'b1;
    end else if (br_en && br_flag) begin
      pc_next       = br_target;
      redirect_next = 1'b1;
      br_inc        = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f         <= RESET_PC;
      redirect     <= 1'b0;
      br_taken_cnt <= 32'd0;
    end else begin
      pc_f     <= pc_next;
      redirect <= redirect_next;
      if (br_inc && (br_taken_cnt != 32'hFFFF_FFFF))
        br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed cases plus randomized
// control traffic against a behavioural next-PC model.
module tb_fetch_pc_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset, stall, br_en, br_flag, j_en, jr_en;
  logic [31:0] pc_d, rs_val;
  logic [15:0] imm16;
  logic [25:0] instr_index;
`ifdef FETCH_PC_EXC_EN
  logic        exc_req, eret;
  logic [31:0] epc;
`endif
  logic [31:0] pc_f, br_taken_cnt;
  logic        adel_f, redirect;

  fetch_pc_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .br_en(br_en), .br_flag(br_flag),
    .j_en(j_en), .jr_en(jr_en), .pc_d(pc_d), .imm16(imm16),
    .instr_index(instr_index), .rs_val(rs_val),
`ifdef FETCH_PC_EXC_EN
    .exc_req(exc_req), .eret(eret), .epc(epc),
`endif
    .pc_f(pc_f), .adel_f(adel_f), .redirect(redirect), .br_taken_cnt(br_taken_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] m_pc, m_cnt;
  bit          m_redir, m_flush;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit exp_adel(input logic [31:0] a);
    return (a % 4 != 0) || (a < IMEM_LO) || (a > IMEM_HI);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    pc_f, m_pc);
    chk({tag, ".adel"},  {31'b0, adel_f}, {31'b0, exp_adel(m_pc)});
    chk({tag, ".redir"}, {31'b0, redirect}, {31'b0, m_redir});
    chk({tag, ".cnt"},   br_taken_cnt, m_cnt);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_cnt = 0; m_redir = 0; m_flush = 0;
  endtask

  // Apply the spec's priority list to the currently driven inputs.
  task automatic model_edge();
    logic [31:0] nxt;
    bit r, taken, fl;
    nxt = m_pc + 4; r = 0; taken = 0; fl = 0;
`ifdef FETCH_PC_EXC_EN
    if (exc_req)      begin nxt = EXC_PC; r = 1; fl = 1; end
    else if (eret)    begin nxt = epc;    r = 1; fl = 1; end
    else if (m_flush) begin nxt = m_pc + 4; end
    else
`endif
    if (stall)               nxt = m_pc;
    else if (jr_en)          begin nxt = rs_val; r = 1; end
    else if (j_en)           begin nxt = (pc_d & 32'hF000_0000) | (32'(instr_index) * 4); r = 1; end
    else if (br_en && br_flag) begin
      nxt = pc_d + 32'(4 + 4 * int'($signed(imm16))); r = 1; taken = 1;
    end
    m_pc = nxt; m_redir = r; m_flush = fl;
    if (taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_en = 0; br_flag = 0; j_en = 0; jr_en = 0;
    pc_d = 0; imm16 = 0; instr_index = 0; rs_val = 0;
`ifdef FETCH_PC_EXC_EN
    exc_req = 0; eret = 0; epc = 0;
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1;
    #2;
    model_reset();
    check_all({tag, ".hold"});
    reset = 0;
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    #12 reset = 0;
    #1 check_all("rst0");

    step("seq1");
    step("seq2");
    stall = 1; step("stall_hold"); stall = 0;

    step("seq3");
    pulse_reset("midrun_rst");

    br_en = 1; br_flag = 1; pc_d = 32'h3010; imm16 = 16'hFFFC;
    step("br_taken");
    br_flag = 0; step("br_not");
    br_flag = 1; stall = 1; step("br_stalled");
    stall = 0; step("br_after_stall");
    idle_inputs();

    jr_en = 1; rs_val = 32'h3002; step("jr_mis");
    jr_en = 0; j_en = 1; pc_d = 32'h3008; instr_index = 26'h0000C40; step("j");
    idle_inputs();

    jr_en = 1; rs_val = 32'h5000; step("jr_pend");
    idle_inputs();
    pulse_reset("redir_rst");

`ifdef FETCH_PC_EXC_EN
    exc_req = 1; stall = 1; step("exc_stall");
    exc_req = 0; stall = 0; br_en = 1; br_flag = 1; pc_d = 32'h3010; imm16 = 16'h0010;
    step("flush_ignore");
    idle_inputs(); eret = 1; epc = 32'h3020; step("eret");
    idle_inputs(); exc_req = 1; step("exc_a");
    step("exc_in_flush");
    idle_inputs(); stall = 1; step("flush_stall");
    idle_inputs();
`endif

    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 4) == 0);
      jr_en       = ($urandom_range(0, 7) == 0);
      j_en        = ($urandom_range(0, 7) == 0);
      br_en       = ($urandom_range(0, 2) == 0);
      br_flag     = $urandom_range(0, 1) != 0;
      pc_d        = 32'h3000 + ($urandom_range(0, 32'h3fff) & 32'hfffc);
      imm16       = 16'($urandom);
      instr_index = 26'($urandom);
      rs_val      = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h3fff) & 32'hfffc);
`ifdef FETCH_PC_EXC_EN
      exc_req     = ($urandom_range(0, 15) == 0);
      eret        = ($urandom_range(0, 15) == 0);
      epc         = 32'h3000 + ($urandom_range(0, 32'h3fff) & 32'hfffc);
`endif
      step("rand");
      if (i == 200) pulse_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
